hilo_div_ctrl: RTL and testbench

EX-stage controller for the iterative divider and the HI/LO register pair. It decodes DIV/DIVU/MTHI/MTLO/MFHI/MFLO from EX and issues a one-cycle start with operands to the divider. It stalls EX while the divide is in flight, captures quotient and remainder into LO/HI on completion, and cancels the divider on pipeline flush or watchdog timeout.

---
 rtl/hilo_div_ctrl.sv | 141 ++++++++++++++
 tb/tb_hilo_div_ctrl.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/hilo_div_ctrl.sv
// hilo_div_ctrl: EX-stage controller for the iterative divider and the HI/LO pair.
// Decodes DIV/DIVU/MTHI/MTLO/MFHI/MFLO, hands DIV/DIVU to the divider with a
// one-cycle start, holds EX while the divide runs, writes quotient/remainder
// into LO/HI on completion, and cancels the divider on flush or watchdog expiry.
// Optional build macro: DIVZERO_SKIP_EN -- DIV/DIVU with a zero divisor is
// retired in one cycle without starting the divider and without touching HI/LO.
module hilo_div_ctrl #(
    parameter int MAX_WAIT = 12,
    parameter int DATA_W   = 32
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              ex_valid,
    input  logic [2:0]        ex_op,
    input  logic [DATA_W-1:0] ex_src_a,
    input  logic [DATA_W-1:0] ex_src_b,
    input  logic              ex_flush,
    output logic              ex_stall,
    output logic [DATA_W-1:0] mf_data,
    output logic [DATA_W-1:0] hi,
    output logic [DATA_W-1:0] lo,
    output logic              timeout_err,
    output logic              div_start,
    output logic              div_signed,
    output logic [DATA_W-1:0] div_x,
    output logic [DATA_W-1:0] div_y,
    output logic              div_cancel,
    input  logic [DATA_W-1:0] div_s,
    input  logic [DATA_W-1:0] div_r,
    input  logic              div_complete
);

    localparam int CNT_W = (MAX_WAIT > 2) ? $clog2(MAX_WAIT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_WAIT - 1);

    localparam logic [2:0] OP_DIV  = 3'd1;
    localparam logic [2:0] OP_DIVU = 3'd2;
    localparam logic [2:0] OP_MTHI = 3'd3;
    localparam logic [2:0] OP_MTLO = 3'd4;
    localparam logic [2:0] OP_MFHI = 3'd5;
    localparam logic [2:0] OP_MFLO = 3'd6;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] wait_cnt;

    logic ex_go;
    logic op_is_div;
    logic div_ok;
    logic issue;
    logic busy;
    logic cancel_flush;
    logic cancel_tmo;

    // Watchdog counter step: stops at the last value instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        if (v == CNT_LAST)
            return v;
        return v + CNT_W'(1);
    endfunction

    assign ex_go     = ex_valid & ~ex_flush;
    assign op_is_div = (ex_op == OP_DIV) | (ex_op == OP_DIVU);

`ifdef DIVZERO_SKIP_EN
    // A zero divisor never reaches the divider; the instruction simply retires.
    assign div_ok = (ex_src_b != '0);
`else
    assign div_ok = 1'b1;
`endif

    assign busy  = (state == ST_BUSY);
    assign issue = ex_go & op_is_div & div_ok & (state == ST_IDLE);

    // Flush outranks completion; the watchdog only fires when neither happened.
    assign cancel_flush = busy & ex_flush;
    assign cancel_tmo   = busy & ~ex_flush & ~div_complete & (wait_cnt == CNT_LAST);

    // Divider handshake and EX hold; operands are presented unconditionally.
    always_comb begin
        div_start  = issue & resetn;
        div_signed = (ex_op == OP_DIV) & resetn;
        div_x      = ex_src_a;
        div_y      = ex_src_b;
        div_cancel = cancel_flush | cancel_tmo;
        ex_stall   = issue | (busy & ~div_complete & ~cancel_flush & ~cancel_tmo);
    end

    // MFHI/MFLO read straight from the architectural registers, no bypass.
    always_comb begin
        mf_data = '0;
        case (ex_op)
            OP_MFHI: mf_data = hi;
            OP_MFLO: mf_data = lo;
            default: mf_data = '0;
        endcase
    end

    // Controller FSM with watchdog, sticky timeout flag and HI/LO updates.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state       <= ST_IDLE;
            wait_cnt    <= '0;
            timeout_err <= 1'b0;
            hi          <= '0;
            lo          <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (issue) begin
                        state    <= ST_BUSY;
                        wait_cnt <= '0;
                    end else if (ex_go && ex_op == OP_MTHI) begin
                        hi <= ex_src_a;
                    end else if (ex_go && ex_op == OP_MTLO) begin
                        lo <= ex_src_a;
                    end
                end
                ST_BUSY: begin
                    wait_cnt <= sat_inc(wait_cnt);
                    if (ex_flush) begin
                        state <= ST_IDLE;
                    end else if (div_complete) begin
                        hi    <= div_r;
                        lo    <= div_s;
                        state <= ST_IDLE;
                    end else if (wait_cnt == CNT_LAST) begin
                        timeout_err <= 1'b1;
                        state       <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_hilo_div_ctrl.sv
// Scoreboard bench for hilo_div_ctrl. The bench plays the divider itself,
// keeps an architectural HI/LO model, and checks each retiring EX instruction.
module tb_hilo_div_ctrl;

    localparam int MAX_WAIT = 12;

    logic        clk = 1'b0;
    logic        resetn;
    logic        ex_valid;
    logic [2:0]  ex_op;
    logic [31:0] ex_src_a, ex_src_b;
    logic        ex_flush;
    logic        ex_stall;
    logic [31:0] mf_data, hi, lo;
    logic        timeout_err;
    logic        div_start, div_signed, div_cancel;
    logic [31:0] div_x, div_y, div_s, div_r;
    logic        div_complete;

    hilo_div_ctrl #(.MAX_WAIT(MAX_WAIT)) dut (
        .clk(clk), .resetn(resetn),
        .ex_valid(ex_valid), .ex_op(ex_op), .ex_src_a(ex_src_a), .ex_src_b(ex_src_b),
        .ex_flush(ex_flush), .ex_stall(ex_stall), .mf_data(mf_data),
        .hi(hi), .lo(lo), .timeout_err(timeout_err),
        .div_start(div_start), .div_signed(div_signed), .div_x(div_x), .div_y(div_y),
        .div_cancel(div_cancel), .div_s(div_s), .div_r(div_r), .div_complete(div_complete)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] mf;
        int          starts;
        logic        sgn;
        logic        cancel;
        int          stalls;
        logic [31:0] hi;
        logic [31:0] lo;
        logic        tmo;
    } exp_t;

    exp_t        exp_q[$];
    int          n_cmp = 0;
    int          n_err = 0;
    logic [31:0] ref_hi, ref_lo;
    logic        ref_tmo;

    function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, expv, $time);
        end
    endfunction

    // Divider behaviour as plain arithmetic; x/0 returns all-ones quotient, remainder x.
    function automatic void div_ref(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                                    output logic [31:0] q, output logic [31:0] r);
        logic signed [31:0] sa, sb;
        sa = a; sb = b;
        if (b == 32'd0) begin
            q = 32'hFFFF_FFFF; r = a;
        end else if (sgn) begin
            q = sa / sb; r = sa % sb;
        end else begin
            q = a / b; r = a % b;
        end
    endfunction

    // mode 0: divider completes in BUSY cycle k (k=0 on non-DIV = stray complete)
    // mode 1: flush in cycle k of the instruction (0 = issue cycle)
    // mode 2: divider never answers
    task automatic run_instr(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                             input int mode, input int k);
        exp_t        e;
        logic        isdiv, skip, killed;
        logic [31:0] q, r;
        int          c, lat, fl;
        bit          done;
        isdiv = (op == 3'd1) || (op == 3'd2);
`ifdef DIVZERO_SKIP_EN
        skip = isdiv && (b == 32'd0);
`else
        skip = 1'b0;
`endif
        killed = (mode == 1) && (k == 0);
        lat = (mode == 0) ? k : -1;
        fl  = (mode == 1) ? k : -1;
        div_ref(op == 3'd1, a, b, q, r);
        e.mf     = (op == 3'd5) ? ref_hi : (op == 3'd6) ? ref_lo : 32'd0;
        e.sgn    = (op == 3'd1);
        e.starts = 0; e.cancel = 1'b0; e.stalls = 0;
        if (isdiv && !skip && !killed) begin
            e.starts = 1;
            case (mode)
                0: begin e.stalls = k; ref_hi = r; ref_lo = q; end
                1: begin e.stalls = k; e.cancel = 1'b1; end
                default: begin e.stalls = MAX_WAIT; e.cancel = 1'b1; ref_tmo = 1'b1; end
            endcase
        end else if (!isdiv && !killed) begin
            if (op == 3'd3) ref_hi = a;
            if (op == 3'd4) ref_lo = a;
        end
        e.hi = ref_hi; e.lo = ref_lo; e.tmo = ref_tmo;
        exp_q.push_back(e);
        ex_valid = 1'b1; ex_op = op; ex_src_a = a; ex_src_b = b;
        c = 0; done = 0;
        while (!done) begin
            ex_flush     = (c == fl);
            div_complete = (c == lat);
            if (c == lat && isdiv) begin
                div_s = q; div_r = r;
            end else begin
                div_s = $urandom; div_r = $urandom;
            end
            @(negedge clk);
            if (!ex_stall) done = 1;
            @(posedge clk); #1;
            c++;
            if (!done && c > 40) begin
                n_cmp++; n_err++;
                $display("FAIL stall_bound: ex_stall still high after %0d cycles, required low", c);
                done = 1;
            end
        end
        ex_valid = 1'b0; ex_flush = 1'b0; div_complete = 1'b0;
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            ex_valid = 1'b0; ex_op = 3'($urandom); ex_src_a = $urandom; ex_flush = $urandom_range(0, 1);
            @(posedge clk); #1;
        end
        ex_flush = 1'b0;
    endtask

    // Monitor: pops an expectation whenever an instruction leaves EX.
    initial begin
        int   st_cnt, start_cnt;
        logic sgn_seen;
        exp_t e;
        st_cnt = 0; start_cnt = 0; sgn_seen = 1'b0;
        forever begin
            @(negedge clk);
            if (!resetn) begin
                st_cnt = 0; start_cnt = 0;
            end else begin
                if (div_start) begin start_cnt++; sgn_seen = div_signed; end
                if (ex_stall) st_cnt++;
                if (ex_valid && !ex_stall) begin
                    if (exp_q.size() == 0) begin
                        n_cmp++; n_err++;
                        $display("FAIL unexpected_retire: op %0d retired, none expected", ex_op);
                    end else begin
                        e = exp_q.pop_front();
                        chk("mf_data", mf_data, e.mf);
                        chk("div_cancel", 32'(div_cancel), 32'(e.cancel));
                        chk("stall_cycles", 32'(st_cnt), 32'(e.stalls));
                        chk("div_start_pulses", 32'(start_cnt), 32'(e.starts));
                        if (e.starts > 0 && start_cnt > 0)
                            chk("div_signed", 32'(sgn_seen), 32'(e.sgn));
                        @(posedge clk); #1;
                        chk("hi", hi, e.hi);
                        chk("lo", lo, e.lo);
                        chk("timeout_err", 32'(timeout_err), 32'(e.tmo));
                    end
                    st_cnt = 0; start_cnt = 0;
                end
            end
        end
    end

    initial begin
        logic [2:0]  op;
        logic [31:0] a, b;
        int          sel;
        resetn = 1'b0; ex_valid = 1'b0; ex_op = 3'd5; ex_src_a = '0; ex_src_b = '0;
        ex_flush = 1'b0; div_s = '0; div_r = '0; div_complete = 1'b0;
        ref_hi = '0; ref_lo = '0; ref_tmo = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_hi", hi, 32'd0);
        chk("rst_lo", lo, 32'd0);
        chk("rst_timeout_err", 32'(timeout_err), 32'd0);
        chk("rst_mf_data", mf_data, 32'd0);
        chk("rst_div_cancel", 32'(div_cancel), 32'd0);
        @(negedge clk); resetn = 1'b1;
        @(posedge clk); #1;

        run_instr(3'd2, 32'd100, 32'd7, 0, 5);
        chk("divu_100_7_hi", hi, 32'd2);
        chk("divu_100_7_lo", lo, 32'd14);
        run_instr(3'd1, 32'hFFFF_FFF9, 32'd2, 0, 3);
        chk("div_m7_2_lo", lo, 32'hFFFF_FFFD);
        chk("div_m7_2_hi", hi, 32'hFFFF_FFFF);
        run_instr(3'd2, 32'd50, 32'd5, 1, 3);
        run_instr(3'd2, 32'd9, 32'd3, 0, 8);
        chk("divu_9_3_lo", lo, 32'd3);
        chk("divu_9_3_hi", hi, 32'd0);
        run_instr(3'd3, 32'h1234, 32'd0, 0, 99);
        run_instr(3'd5, 32'd0, 32'd0, 0, 99);
        run_instr(3'd4, 32'h55, 32'd0, 1, 0);
        run_instr(3'd6, 32'd0, 32'd0, 0, 99);
        run_instr(3'd1, 32'd77, 32'd3, 1, 0);
        run_instr(3'd1, 32'd1000, 32'd9, 2, 0);
        chk("timeout_sticky_set", 32'(timeout_err), 32'd1);
        run_instr(3'd2, 32'd81, 32'd4, 0, 2);

        // Reset in the middle of a divide.
        ex_valid = 1'b1; ex_op = 3'd2; ex_src_a = 32'd77; ex_src_b = 32'd7;
        repeat (3) begin @(posedge clk); #1; end
        resetn = 1'b0;
        #1;
        chk("midrst_hi", hi, 32'd0);
        chk("midrst_lo", lo, 32'd0);
        chk("midrst_timeout_err", 32'(timeout_err), 32'd0);
        chk("midrst_div_cancel", 32'(div_cancel), 32'd0);
        ex_valid = 1'b0;
        ref_hi = '0; ref_lo = '0; ref_tmo = 1'b0;
        @(posedge clk); @(posedge clk); #3;
        resetn = 1'b1;
        @(posedge clk); #1;
        run_instr(3'd2, 32'd9, 32'd3, 0, 4);

        run_instr(3'd3, 32'hAAAA_0001, 32'd0, 0, 99);
        run_instr(3'd2, 32'd5, 32'd0, 0, 4);
`ifdef DIVZERO_SKIP_EN
        chk("divu_5_0_hi", hi, 32'hAAAA_0001);
`else
        chk("divu_5_0_lo", lo, 32'hFFFF_FFFF);
        chk("divu_5_0_hi", hi, 32'd5);
`endif

        for (int n = 0; n < 250; n++) begin
            op = 3'($urandom);
            a  = $urandom;
            b  = ($urandom_range(0, 5) == 0) ? 32'd0 : $urandom;
            if (op == 3'd1 && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) b = 32'd1;
            sel = $urandom_range(0, 19);
            if (op == 3'd1 || op == 3'd2) begin
                if (sel < 12)      run_instr(op, a, b, 0, $urandom_range(1, 8));
                else if (sel < 19) run_instr(op, a, b, 1, $urandom_range(0, 8));
                else               run_instr(op, a, b, 2, 0);
            end else begin
                if (sel < 4)       run_instr(op, a, b, 1, 0);
                else if (sel < 10) run_instr(op, a, b, 0, 0);
                else               run_instr(op, a, b, 0, 99);
            end
            if ($urandom_range(0, 3) == 0) idle_cycles($urandom_range(1, 2));
        end

        repeat (3) @(posedge clk);
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule
